// File: rtl/ws2812_pkg.sv
// Shared state encoding and default 50 MHz timing for the WS2812 matrix line driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StLatch = 2'd0,
        StHigh  = 2'd1,
        StMid   = 2'd2,
        StLow   = 2'd3
    } ws_state_e;

    localparam int unsigned MATRIX_W       = 16;
    localparam int unsigned MATRIX_H       = 8;
    localparam int unsigned BITS_PER_PIXEL = 24;

    localparam int unsigned DEF_T0H          = 20;
    localparam int unsigned DEF_T1H          = 40;
    localparam int unsigned DEF_TBIT         = 62;
    localparam int unsigned DEF_RESET_CYCLES = 3000;
    localparam int unsigned DEF_FRAME_BITS   = MATRIX_W * MATRIX_H * BITS_PER_PIXEL;

    // Bits needed to hold values 0..max_count, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire NRZ bit encoder with per-frame latch gap.
// Optional frame_done output when WS2812_FRAME_PULSE_EN is defined.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H          = DEF_T0H,
    parameter int unsigned T1H          = DEF_T1H,
    parameter int unsigned TBIT         = DEF_TBIT,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned FRAME_BITS   = DEF_FRAME_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic led_out,
    output logic done
`ifdef WS2812_FRAME_PULSE_EN
    , output logic frame_done
`endif
);

    if (!(T0H >= 2 && T0H < T1H && T1H < TBIT && RESET_CYCLES >= 1)) begin : g_bad_params
        $error("ws2812_bit_encoder: timing parameters out of range");
    end

    // One counter serves both the bit period and the latch gap.
    localparam int unsigned CYC_MAX = (TBIT > RESET_CYCLES) ? TBIT - 1 : RESET_CYCLES - 1;
    localparam int unsigned CYC_W   = cnt_width(CYC_MAX);
    localparam int unsigned BIT_W   = cnt_width(FRAME_BITS - 1);

    localparam logic [CYC_W-1:0] C_T0H_LAST  = CYC_W'(T0H - 1);
    localparam logic [CYC_W-1:0] C_T1H_LAST  = CYC_W'(T1H - 1);
    localparam logic [CYC_W-1:0] C_TBIT_LAST = CYC_W'(TBIT - 1);
    localparam logic [CYC_W-1:0] C_RST_LAST  = CYC_W'(RESET_CYCLES - 1);
    localparam logic [BIT_W-1:0] B_LAST      = BIT_W'(FRAME_BITS - 1);

    ws_state_e        r_state, w_state_d;
    logic [CYC_W-1:0] r_cyc, w_cyc_d;
    logic [BIT_W-1:0] r_bits, w_bits_d;
    logic             r_bit_q, w_bit_d;
    logic             r_led, w_led_d;
    logic             r_done, w_done_d;

    always_comb begin
        w_state_d = r_state;
        w_cyc_d   = r_cyc + 1'b1;
        w_bits_d  = r_bits;
        w_bit_d   = r_bit_q;
        unique case (r_state)
            StLatch: begin
                if (r_cyc == C_RST_LAST) begin
                    w_state_d = StHigh;
                    w_cyc_d   = '0;
                end
            end
            StHigh: begin
                if (r_cyc == C_T0H_LAST) begin
                    w_state_d = StMid;
                    w_bit_d   = data_in;
                end
            end
            StMid: begin
                if (r_cyc == C_T1H_LAST) begin
                    w_state_d = StLow;
                end
            end
            StLow: begin
                if (r_cyc == C_TBIT_LAST) begin
                    w_cyc_d = '0;
                    if (r_bits == B_LAST) begin
                        w_state_d = StLatch;
                        w_bits_d  = '0;
                    end else begin
                        w_state_d = StHigh;
                        w_bits_d  = r_bits + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StLatch;
                w_cyc_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        w_led_d  = (w_state_d == StHigh) || ((w_state_d == StMid) && w_bit_d);
        w_done_d = (w_state_d == StLow) && (w_cyc_d == C_TBIT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StLatch;
            r_cyc   <= '0;
            r_bits  <= '0;
            r_bit_q <= 1'b0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cyc   <= w_cyc_d;
            r_bits  <= w_bits_d;
            r_bit_q <= w_bit_d;
            r_led   <= w_led_d;
            r_done  <= w_done_d;
        end
    end

    assign led_out = r_led;
    assign done    = r_done;

`ifdef WS2812_FRAME_PULSE_EN
    logic r_frame_done;
    logic w_frame_done_d;

    assign w_frame_done_d = (w_state_d == StLatch) && (w_cyc_d == C_RST_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_done_d;
        end
    end

    assign frame_done = r_frame_done;
`endif

endmodule
